vga_text_buf: RTL and testbench

//  Text-mode character buffer that sits directly upstream of the VGA timing block.
//  It accepts ASCII bytes from the keyboard/CPU side over a valid/ready handshake.

---
 rtl/vga_text_buf_if.sv | 14 +
 rtl/vga_text_buf.sv | 193 +++++++++++++++++++
 tb/tb_vga_text_buf.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_text_buf_if.sv
`default_nettype none
// ============================================================================
// vga_text_buf_if : valid/ready byte-input bundle feeding vga_text_buf
// Revision: 1.0
// ============================================================================
interface vga_text_buf_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;

    modport master (output in_valid, output in_char, input  in_ready);
    modport slave  (input  in_valid, input  in_char, output in_ready);
endinterface
`default_nettype wire

// File: rtl/vga_text_buf.sv
`default_nettype none
// ============================================================================
// vga_text_buf : COLS x ROWS text VRAM with cursor, wrap and circular scroll
// Revision: 1.0
// ============================================================================
module vga_text_buf #(
    parameter int COLS = 70,
    parameter int ROWS = 30
) (
    input  logic          pclk,
    input  logic          reset_n,
    vga_text_buf_if.slave in_bus,
    input  logic [6:0]    rd_x,
    input  logic [4:0]    rd_y,
    output logic [7:0]    rd_ascii,
    output logic [6:0]    cur_x,
    output logic [4:0]    cur_y
);

    localparam int             c_cells     = COLS * ROWS;
    localparam int             c_aw        = $clog2(c_cells);
    localparam logic [c_aw-1:0] c_last_cell = c_aw'(c_cells - 1);
    localparam logic [c_aw-1:0] c_cols_a    = c_aw'(COLS);
    localparam logic [c_aw-1:0] c_last_colc = c_aw'(COLS - 1);
    localparam logic [6:0]     c_cols7     = 7'(COLS);
    localparam logic [6:0]     c_last_col  = 7'(COLS - 1);
    localparam logic [4:0]     c_rows5     = 5'(ROWS);
    localparam logic [4:0]     c_last_row  = 5'(ROWS - 1);
    localparam logic [5:0]     c_rows6     = 6'(ROWS);

    typedef enum logic [1:0] {
        ST_CLEAR      = 2'd0,
        ST_IDLE       = 2'd1,
        ST_SCROLL_CLR = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [c_aw-1:0] cnt_q, cnt_d;
    logic [6:0]      cur_x_q, cur_x_d;
    logic [4:0]      cur_y_q, cur_y_d;
    logic [4:0]      top_row_q, top_row_d;
    logic [4:0]      scroll_row_q, scroll_row_d;
    logic [7:0]      rd_ascii_q, rd_ascii_d;

    logic            we;
    logic [c_aw-1:0] waddr;
    logic [7:0]      wdata;
    logic            do_nl;
    logic [4:0]      cur_prow;
    logic            rd_ok;
    logic [c_aw-1:0] rd_addr;

    logic [7:0]      vram [c_cells];

    // Explicit compare/subtract wrap: ROWS is not a power of two.
    function automatic logic [4:0] phys_row(input logic [4:0] lrow, input logic [4:0] top);
        logic [5:0] s;
        s = {1'b0, lrow} + {1'b0, top};
        if (s >= c_rows6) begin
            s = s - c_rows6;
        end
        return s[4:0];
    endfunction

    function automatic logic [c_aw-1:0] cell_addr(input logic [4:0] prow, input logic [6:0] col);
        return c_aw'(prow) * c_cols_a + c_aw'(col);
    endfunction

    assign cur_prow = phys_row(cur_y_q, top_row_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        top_row_d    = top_row_q;
        scroll_row_d = scroll_row_q;
        we           = 1'b0;
        waddr        = '0;
        wdata        = 8'h20;
        do_nl        = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                if (cnt_q == c_last_cell) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_SCROLL_CLR: begin
                we    = 1'b1;
                waddr = cell_addr(scroll_row_q, cnt_q[6:0]);
                if (cnt_q == c_last_colc) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_IDLE: begin
                if (in_bus.in_valid) begin
                    if (in_bus.in_char >= 8'h20 && in_bus.in_char <= 8'h7E) begin
                        we    = 1'b1;
                        waddr = cell_addr(cur_prow, cur_x_q);
                        wdata = in_bus.in_char;
                        if (cur_x_q == c_last_col) begin
                            do_nl = 1'b1;
                        end else begin
                            cur_x_d = cur_x_q + 7'd1;
                        end
                    end else if (in_bus.in_char == 8'h0A) begin
                        do_nl = 1'b1;
                    end else if (in_bus.in_char == 8'h0D) begin
                        cur_x_d = '0;
                    end else if (in_bus.in_char == 8'h08) begin
                        if (cur_x_q != 7'd0) begin
                            cur_x_d = cur_x_q - 7'd1;
                            we      = 1'b1;
                            waddr   = cell_addr(cur_prow, cur_x_q - 7'd1);
                        end
                    end

                    // Newline from either 0x0A or a wrap off the last column.
                    if (do_nl) begin
                        cur_x_d = '0;
                        if (cur_y_q < c_last_row) begin
                            cur_y_d = cur_y_q + 5'd1;
                        end else begin
                            top_row_d    = (top_row_q == c_last_row) ? 5'd0 : top_row_q + 5'd1;
                            scroll_row_d = top_row_q;
                            cnt_d        = '0;
                            state_d      = ST_SCROLL_CLR;
                        end
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign rd_ok   = (rd_x < c_cols7) && (rd_y < c_rows5);
    assign rd_addr = cell_addr(phys_row(rd_y, top_row_q), rd_x);

    always_comb begin
        rd_ascii_d = 8'h20;
        if (rd_ok) begin
            rd_ascii_d = vram[rd_addr];
        end
    end

    always_ff @(posedge pclk) begin
        if (we) begin
            vram[waddr] <= wdata;
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            top_row_q    <= '0;
            scroll_row_q <= '0;
            rd_ascii_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            top_row_q    <= top_row_d;
            scroll_row_q <= scroll_row_d;
            rd_ascii_q   <= rd_ascii_d;
        end
    end

    assign in_bus.in_ready = (state_q == ST_IDLE);
    assign rd_ascii        = rd_ascii_q;
    assign cur_x           = cur_x_q;
    assign cur_y           = cur_y_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_text_buf.sv
`default_nettype none
// ============================================================================
// tb_vga_text_buf : directed self-checking bench for vga_text_buf
// Revision: 1.0
// ============================================================================
module tb_vga_text_buf;

    localparam int COLS = 70;
    localparam int ROWS = 30;

    logic       pclk    = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] rd_x;
    logic [4:0] rd_y;
    logic [7:0] rd_ascii;
    logic [6:0] cur_x;
    logic [4:0] cur_y;

    int n_vec = 0;
    int n_err = 0;
    int n;

    logic [7:0] scr [ROWS][COLS];

    vga_text_buf_if u_if ();

    vga_text_buf #(.COLS(COLS), .ROWS(ROWS)) u_dut (
        .pclk     (pclk),
        .reset_n  (reset_n),
        .in_bus   (u_if.slave),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_ascii (rd_ascii),
        .cur_x    (cur_x),
        .cur_y    (cur_y)
    );

    always #20 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after one registered read.
    task automatic rd_cell(input int x, input int y, output logic [7:0] v);
        rd_x = 7'(x);
        rd_y = 5'(y);
        @(posedge pclk);
        #1 v = rd_ascii;
        @(negedge pclk);
    endtask

    task automatic check_cell(input string tag, input int x, input int y, input logic [7:0] e);
        logic [7:0] v;
        rd_cell(x, y, v);
        chk(tag, {24'd0, v}, {24'd0, e});
    endtask

    task automatic scr_blank();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                scr[y][x] = 8'h20;
    endtask

    task automatic sweep(input string tag);
        logic [7:0] v;
        int bad;
        bad = 0;
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                rd_cell(x, y, v);
                if (v !== scr[y][x]) bad++;
            end
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        while (!u_if.in_ready && t < 5000) begin
            @(negedge pclk);
            t++;
        end
        if (!u_if.in_ready) chk("send_ready_timeout", 32'd0, 32'd1);
        u_if.in_valid = 1'b1;
        u_if.in_char  = b;
        @(negedge pclk);
        u_if.in_valid = 1'b0;
    endtask

    // Counts active edges until in_ready rises; called at a negedge while busy.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (cnt < 5000) begin
            @(posedge pclk);
            cnt++;
            #1;
            if (u_if.in_ready) break;
        end
        @(negedge pclk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.in_valid = 1'b0;
        u_if.in_char  = 8'h00;
        rd_x          = '0;
        rd_y          = '0;
        reset_n       = 1'b0;
        repeat (3) @(negedge pclk);

        chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd0);
        chk("rst_rd_ascii", {24'd0, rd_ascii}, 32'h00);
        chk("rst_cur_x",    {25'd0, cur_x}, 32'd0);
        chk("rst_cur_y",    {27'd0, cur_y}, 32'd0);

        reset_n = 1'b1;
        wait_ready(n);
        chk("clear_cycles", 32'(n), 32'd2100);
        scr_blank();
        sweep("clear_all_space");

        send("A");
        send("B");
        chk("ab_cur_x", {25'd0, cur_x}, 32'd2);
        chk("ab_cur_y", {27'd0, cur_y}, 32'd0);
        check_cell("ab_cell00", 0, 0, 8'h41);
        check_cell("ab_cell10", 1, 0, 8'h42);

        send(8'h0D);
        chk("cr_cur_x", {25'd0, cur_x}, 32'd0);
        repeat (70) send("C");
        chk("wrap_cur_x", {25'd0, cur_x}, 32'd0);
        chk("wrap_cur_y", {27'd0, cur_y}, 32'd1);
        send("D");
        check_cell("wrap_d_at_01", 0, 1, "D");
        check_cell("row0_last_c", 69, 0, "C");
        check_cell("oob_x70", 70, 0, 8'h20);
        check_cell("oob_y30", 0, 30, 8'h20);

        repeat (28) send(8'h0A);
        chk("nl_cur_y29", {27'd0, cur_y}, 32'd29);
        chk("nl_cur_x0",  {25'd0, cur_x}, 32'd0);
        send("E");
        send(8'h0A);
        wait_ready(n);
        chk("scroll_cycles", 32'(n), 32'd70);
        chk("scroll_cur_y", {27'd0, cur_y}, 32'd29);
        chk("scroll_cur_x", {25'd0, cur_x}, 32'd0);
        scr_blank();
        scr[0][0]  = "D";
        scr[28][0] = "E";
        sweep("after_scroll");

        send("X");
        check_cell("bs_x_written", 0, 29, "X");
        chk("bs_pre_cur_x", {25'd0, cur_x}, 32'd1);
        send(8'h08);
        chk("bs_cur_x", {25'd0, cur_x}, 32'd0);
        check_cell("bs_cell_space", 0, 29, 8'h20);
        send(8'h08);
        chk("bs0_cur_x", {25'd0, cur_x}, 32'd0);
        chk("bs0_cur_y", {27'd0, cur_y}, 32'd29);
        check_cell("bs0_cell", 0, 29, 8'h20);

        send("a"); send("b"); send("c"); send("d"); send("e");
        chk("cr5_pre", {25'd0, cur_x}, 32'd5);
        send(8'h0D);
        chk("cr5_cur_x", {25'd0, cur_x}, 32'd0);
        check_cell("cr5_text_kept", 4, 29, "e");
        send(8'h01);
        chk("ctl_cur_x", {25'd0, cur_x}, 32'd0);
        check_cell("ctl_no_write", 0, 29, "a");

        send(8'h0A);
        u_if.in_valid = 1'b1;
        u_if.in_char  = "Z";
        n = 0;
        while (!u_if.in_ready && n < 200) begin
            @(negedge pclk);
            n++;
        end
        @(negedge pclk);
        u_if.in_valid = 1'b0;
        chk("held_z_cur_x", {25'd0, cur_x}, 32'd1);
        check_cell("held_z_cell0", 0, 29, "Z");
        check_cell("held_z_cell1", 1, 29, 8'h20);
        check_cell("held_scrolled_a", 0, 28, "a");
        check_cell("held_scrolled_e", 4, 28, "e");

        rd_x = 7'd0;
        rd_y = 5'd28;
        send(8'h0A);
        repeat (10) @(negedge pclk);
        chk("pre_abort_rd", {24'd0, rd_ascii}, 32'h5A);
        #5 reset_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, u_if.in_ready}, 32'd0);
        chk("abort_rd_ascii", {24'd0, rd_ascii}, 32'h00);
        chk("abort_cur_x",    {25'd0, cur_x}, 32'd0);
        chk("abort_cur_y",    {27'd0, cur_y}, 32'd0);
        @(negedge pclk);
        reset_n = 1'b1;
        wait_ready(n);
        chk("reclear_cycles", 32'(n), 32'd2100);
        scr_blank();
        sweep("reclear_all_space");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
